serial_pad_reader: RTL and testbench

SERIAL_PAD_READER -- requirements
Module: serial_pad_reader

---
 rtl/serial_pad_pkg.sv | 29 ++
 rtl/pad_tick_gen.sv | 38 +++
 rtl/serial_pad_reader.sv | 230 +++++++++++++++++++++++
 tb/tb_serial_pad_reader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pad_pkg
// Description : Shared types and constants for the serial game-pad reader.
//               Holds the poll state enumeration, the latch strobe length
//               (in ticks) and the width of the per-state tick counter.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pad_pkg;

    // Poll sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_HI = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_UPDATE = 3'd4,
        ST_GAP    = 3'd5
    } pad_state_t;

    // Number of ticks the latch strobe is held high.
    localparam int unsigned LATCH_TICKS = 2;

    // Width of the tick counter used inside LATCH and GAP; sized so the
    // largest legal POLL_GAP (65535) fits.
    localparam int unsigned TICK_CNT_W = 16;

endpackage : serial_pad_pkg
`default_nettype wire

// File: rtl/pad_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pad_tick_gen
// Description : Free-running divider producing a one-clock tick every DIV
//               clocks. The counter runs 0..DIV-1 and the tick is asserted
//               while the count equals DIV-1.
// Ports       : clock - sole clock
//               reset - asynchronous active-low reset (counter to 0)
//               tick  - one-clock strobe, period DIV clocks
// Revision    : 1.0 - initial release
// ============================================================================
module pad_tick_gen #(
    parameter int unsigned DIV = 128
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned   CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tick = (r_count == c_last);

endmodule : pad_tick_gen
`default_nettype wire

// File: rtl/serial_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : serial_pad_reader
// Description : Polls NUM_PADS NES/SNES-style serial game pads in parallel.
//               Each poll strobes latch for two ticks, then clocks out the
//               remaining NUM_BITS-1 bits with pad_clk, and finally publishes
//               the active-high button word for every pad together with a
//               valid pulse and a per-pad changed flag. Polls repeat after
//               POLL_GAP idle ticks while enable stays high.
// Ports       : clock    - sole clock
//               reset    - asynchronous active-low reset
//               enable   - polling permitted when high
//               pad_data - serial data from each pad (active-low buttons)
//               latch    - shared latch strobe (registered)
//               pad_clk  - shared shift clock (registered)
//               buttons  - active-high state, pad p bit k at p*NUM_BITS+k
//               valid    - one-clock pulse when buttons updates
//               changed  - per-pad pulse with valid, set if the word changed
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pad_reader
    import serial_pad_pkg::*;
#(
    parameter int unsigned NUM_PADS = 2,
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned DIV      = 128,
    parameter int unsigned POLL_GAP = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         valid,
    output logic [NUM_PADS-1:0]          changed
);

    localparam int unsigned             BIT_W        = $clog2(NUM_BITS) + 1;
    localparam logic [BIT_W-1:0]        c_last_bit   = BIT_W'(NUM_BITS - 1);
    localparam logic [TICK_CNT_W-1:0]   c_latch_last = TICK_CNT_W'(LATCH_TICKS - 1);
    localparam logic [TICK_CNT_W-1:0]   c_gap_last   = TICK_CNT_W'(POLL_GAP - 1);
    localparam bit                      c_single_bit = (NUM_BITS == 1);

    logic                               w_tick;
    logic                               w_sample;
    logic                               w_finish;
    logic [NUM_PADS-1:0]                r_sync1;
    logic [NUM_PADS-1:0]                r_sync2;
    pad_state_t                         r_state;
    logic [TICK_CNT_W-1:0]              r_ticks;
    logic [BIT_W-1:0]                   r_bit;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  r_shift;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  w_shift_next;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  r_buttons;
    logic [NUM_PADS-1:0]                w_diff;
    logic [NUM_PADS-1:0]                r_changed;
    logic                               r_latch;
    logic                               r_pad_clk;
    logic                               r_valid;

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    pad_tick_gen #(
        .DIV   (DIV)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // Two-flop synchroniser on the asynchronous pad inputs. The idle level
    // of a pad line is high (no button), so the flops reset to 1.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= pad_data;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-pad shift and change detection. Bits arrive LSB first, so each
    // new sample enters at the MSB and the word shifts right; after
    // NUM_BITS samples bit 0 sits at index 0.
    // ------------------------------------------------------------------
    generate
        for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
            assign w_shift_next[p] = (r_shift[p] >> 1)
                                   | (NUM_BITS'(r_sync2[p]) << (NUM_BITS - 1));
            assign w_diff[p]       = ((~w_shift_next[p]) != r_buttons[p]);
        end
    endgenerate

    // A sample is taken on the tick that closes LATCH and on the tick that
    // closes every CLK_LO. The final sample of the poll moves to UPDATE.
    assign w_sample = w_tick &&
                      (((r_state == ST_LATCH) && (r_ticks == c_latch_last)) ||
                       (r_state == ST_CLK_LO));
    assign w_finish = w_sample &&
                      ((r_state == ST_CLK_LO) ? (r_bit == c_last_bit) : c_single_bit);

    // ------------------------------------------------------------------
    // Sample / publish datapath. buttons, valid and changed are loaded on
    // the edge that enters UPDATE, so they are visible for exactly the one
    // clock spent in UPDATE.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_buttons <= '0;
            r_valid   <= 1'b0;
            r_changed <= '0;
        end else begin
            if (w_sample) begin
                r_shift <= w_shift_next;
            end
            if (w_finish) begin
                r_buttons <= ~w_shift_next;
            end
            r_valid   <= w_finish;
            r_changed <= w_finish ? w_diff : '0;
        end
    end

    // ------------------------------------------------------------------
    // Poll sequencer. latch and pad_clk are set on the same edge as the
    // state they belong to, so each is high for whole states only.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ticks   <= '0;
            r_bit     <= '0;
            r_latch   <= 1'b0;
            r_pad_clk <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick && enable) begin
                        r_state <= ST_LATCH;
                        r_latch <= 1'b1;
                        r_ticks <= '0;
                    end
                end

                ST_LATCH: begin
                    if (w_tick) begin
                        if (r_ticks == c_latch_last) begin
                            r_latch <= 1'b0;
                            r_ticks <= '0;
                            r_bit   <= BIT_W'(1);
                            if (w_finish) begin
                                r_state <= ST_UPDATE;
                            end else begin
                                r_state   <= ST_CLK_HI;
                                r_pad_clk <= 1'b1;
                            end
                        end else begin
                            r_ticks <= r_ticks + TICK_CNT_W'(1);
                        end
                    end
                end

                ST_CLK_HI: begin
                    if (w_tick) begin
                        r_state   <= ST_CLK_LO;
                        r_pad_clk <= 1'b0;
                    end
                end

                ST_CLK_LO: begin
                    if (w_tick) begin
                        if (w_finish) begin
                            r_state <= ST_UPDATE;
                        end else begin
                            r_bit     <= r_bit + BIT_W'(1);
                            r_state   <= ST_CLK_HI;
                            r_pad_clk <= 1'b1;
                        end
                    end
                end

                // Lasts one clock regardless of the tick.
                ST_UPDATE: begin
                    r_state <= ST_GAP;
                    r_ticks <= '0;
                end

                // Enable is only consulted here and in IDLE, so dropping it
                // mid-poll lets the current poll run to completion.
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_ticks == c_gap_last) begin
                            r_ticks <= '0;
                            if (enable) begin
                                r_state <= ST_LATCH;
                                r_latch <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_ticks <= r_ticks + TICK_CNT_W'(1);
                        end
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_latch   <= 1'b0;
                    r_pad_clk <= 1'b0;
                end
            endcase
        end
    end

    assign latch   = r_latch;
    assign pad_clk = r_pad_clk;
    assign buttons = r_buttons;
    assign valid   = r_valid;
    assign changed = r_changed;

endmodule : serial_pad_reader
`default_nettype wire

// File: tb/tb_serial_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pad_reader
// Description : Self-checking bench for serial_pad_reader. Two instances:
//               an NES-style 2-pad/8-bit reader and an SNES-style 1-pad/
//               16-bit reader, both DIV=4, POLL_GAP=8. Each pad is emulated
//               as a parallel-load shift register (load on latch, advance on
//               pad_clk rising); expected buttons/changed come from the
//               emulated words and the previous published word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pad_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             en8;
    logic             en16;
    logic [1:0]       pad8;
    logic [0:0]       pad16;
    logic             latch8, pclk8, valid8;
    logic [15:0]      btn8;
    logic [1:0]       chg8;
    logic             latch16, pclk16, valid16;
    logic [15:0]      btn16;
    logic [0:0]       chg16;

    logic [1:0][7:0]  raw8;
    logic [15:0]      raw16;
    int               idx8  = 0;
    int               idx16 = 0;
    int               checks = 0;
    int               errors = 0;
    logic [15:0]      prev8;
    logic [15:0]      prev16;

    serial_pad_reader #(
        .NUM_PADS (2), .NUM_BITS (8), .DIV (4), .POLL_GAP (8)
    ) u_dut8 (
        .clock (clk), .reset (rst_n), .enable (en8), .pad_data (pad8),
        .latch (latch8), .pad_clk (pclk8), .buttons (btn8),
        .valid (valid8), .changed (chg8)
    );

    serial_pad_reader #(
        .NUM_PADS (1), .NUM_BITS (16), .DIV (4), .POLL_GAP (8)
    ) u_dut16 (
        .clock (clk), .reset (rst_n), .enable (en16), .pad_data (pad16),
        .latch (latch16), .pad_clk (pclk16), .buttons (btn16),
        .valid (valid16), .changed (chg16)
    );

    // ---------------- pad emulation ----------------
    always @(posedge latch8 or posedge pclk8) begin
        if (latch8) idx8 = 0;
        else        idx8 = idx8 + 1;
    end
    always @(posedge latch16 or posedge pclk16) begin
        if (latch16) idx16 = 0;
        else         idx16 = idx16 + 1;
    end
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pad8[p] = (idx8 < 8) ? raw8[p][idx8[2:0]] : 1'b1;
        end
    end
    always_comb begin
        pad16[0] = (idx16 < 16) ? raw16[idx16[3:0]] : 1'b1;
    end

    // ---------------- wait / measure helpers (no checking) ----------------
    task automatic wait_latch8(input int maxc, output int n);
        n = 0;
        while (latch8 !== 1'b1 && n < maxc) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic wait_latch16(input int maxc, output int n);
        n = 0;
        while (latch16 !== 1'b1 && n < maxc) begin
            @(posedge clk); #1; n++;
        end
    endtask

    // Called with latch just seen high (t=0); runs until valid or bound.
    task automatic measure8(output int lat_hi, output int rises,
                            output int pclk_hi, output int vt);
        logic prev;
        lat_hi = 1; rises = 0; pclk_hi = 0; vt = -1; prev = pclk8;
        for (int t = 1; t <= 150; t++) begin
            @(posedge clk); #1;
            if (latch8) lat_hi++;
            if (pclk8) pclk_hi++;
            if (pclk8 && !prev) rises++;
            prev = pclk8;
            if (valid8) begin vt = t; break; end
        end
    endtask

    task automatic measure16(output int rises, output int vt);
        logic prev;
        rises = 0; vt = -1; prev = pclk16;
        for (int t = 1; t <= 250; t++) begin
            @(posedge clk); #1;
            if (pclk16 && !prev) rises++;
            prev = pclk16;
            if (valid16) begin vt = t; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; en8 = 1'b0; en16 = 1'b0;
        raw8  = '1; raw16 = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({latch8, pclk8, valid8, chg8} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl8: got %b expected 00000", {latch8, pclk8, valid8, chg8});
        end
        checks++;
        if (btn8 !== 16'h0000) begin
            errors++; $display("FAIL reset_btn8: got %h expected 0000", btn8);
        end
        checks++;
        if ({latch16, pclk16, valid16, chg16, btn16} !== 20'h0) begin
            errors++; $display("FAIL reset_dut16: got %h expected 00000", {latch16, pclk16, valid16, chg16, btn16});
        end
        prev8 = 16'h0; prev16 = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_poll();
        int n, lh, rs, ph, vt;
        raw8[0] = 8'hF6; raw8[1] = 8'hFF; en8 = 1'b1;
        wait_latch8(20, n);
        checks++;
        if (n !== 4) begin
            errors++; $display("FAIL first_latch_delay: got %0d expected 4", n);
        end
        measure8(lh, rs, ph, vt);
        checks++;
        if (lh !== 8) begin errors++; $display("FAIL latch_width: got %0d expected 8", lh); end
        checks++;
        if (rs !== 7) begin errors++; $display("FAIL pad_clk_pulses: got %0d expected 7", rs); end
        checks++;
        if (ph !== 28) begin errors++; $display("FAIL pad_clk_high: got %0d expected 28", ph); end
        checks++;
        if (vt !== 64) begin errors++; $display("FAIL valid_latency: got %0d expected 64", vt); end
        checks++;
        if (btn8 !== 16'h0009) begin errors++; $display("FAIL first_buttons: got %h expected 0009", btn8); end
        checks++;
        if (chg8 !== 2'b01) begin errors++; $display("FAIL first_changed: got %b expected 01", chg8); end
        @(posedge clk); #1;
        checks++;
        if ({valid8, chg8} !== 3'b000) begin
            errors++; $display("FAIL valid_one_clock: got %b expected 000", {valid8, chg8});
        end
        prev8 = 16'h0009;
    endtask

    task automatic test_repeat_poll();
        int n, lh, rs, ph, vt;
        wait_latch8(60, n);
        checks++;
        if (n !== 31) begin errors++; $display("FAIL gap_length: got %0d expected 31", n); end
        measure8(lh, rs, ph, vt);
        checks++;
        if (vt !== 64) begin errors++; $display("FAIL repeat_latency: got %0d expected 64", vt); end
        checks++;
        if (chg8 !== 2'b00) begin errors++; $display("FAIL repeat_changed: got %b expected 00", chg8); end
        checks++;
        if (btn8 !== 16'h0009) begin errors++; $display("FAIL repeat_buttons: got %h expected 0009", btn8); end
        @(posedge clk); #1;
    endtask

    task automatic test_random_polls();
        int n, lh, rs, ph, vt;
        logic [15:0] exp_b;
        logic [1:0]  exp_c;
        for (int i = 0; i < 6; i++) begin
            raw8[0] = (i == 3) ? raw8[0] : 8'($urandom);
            raw8[1] = (i % 2 == 0) ? raw8[1] : 8'($urandom);
            exp_b    = ~raw8;
            exp_c[0] = (exp_b[7:0]  != prev8[7:0]);
            exp_c[1] = (exp_b[15:8] != prev8[15:8]);
            wait_latch8(60, n);
            checks++;
            if (n !== 31) begin errors++; $display("FAIL rand_gap[%0d]: got %0d expected 31", i, n); end
            measure8(lh, rs, ph, vt);
            checks++;
            if (vt !== 64 || lh !== 8 || rs !== 7) begin
                errors++; $display("FAIL rand_timing[%0d]: got v%0d l%0d r%0d expected v64 l8 r7", i, vt, lh, rs);
            end
            checks++;
            if (btn8 !== exp_b) begin errors++; $display("FAIL rand_buttons[%0d]: got %h expected %h", i, btn8, exp_b); end
            checks++;
            if (chg8 !== exp_c) begin errors++; $display("FAIL rand_changed[%0d]: got %b expected %b", i, chg8, exp_c); end
            prev8 = exp_b;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_enable_drop();
        int n, vt, lat_seen, pclk_seen, val_seen;
        logic [15:0] exp_b;
        logic [1:0]  exp_c;
        raw8[0] = 8'($urandom) & 8'hFE;
        raw8[1] = 8'($urandom);
        exp_b    = ~raw8;
        exp_c[0] = (exp_b[7:0]  != prev8[7:0]);
        exp_c[1] = (exp_b[15:8] != prev8[15:8]);
        wait_latch8(60, n);
        checks++;
        if (latch8 !== 1'b1) begin errors++; $display("FAIL drop_latch_start: got %b expected 1", latch8); end
        repeat (29) begin @(posedge clk); #1; end
        checks++;
        if (pclk8 !== 1'b0) begin errors++; $display("FAIL drop_in_clk_lo: got %b expected 0", pclk8); end
        en8 = 1'b0;
        vt = -1;
        for (int t = 30; t <= 150; t++) begin
            @(posedge clk); #1;
            if (valid8) begin vt = t; break; end
        end
        checks++;
        if (vt !== 64) begin errors++; $display("FAIL drop_latency: got %0d expected 64", vt); end
        checks++;
        if (btn8 !== exp_b || chg8 !== exp_c) begin
            errors++; $display("FAIL drop_result: got %h/%b expected %h/%b", btn8, chg8, exp_b, exp_c);
        end
        prev8 = exp_b;
        lat_seen = 0; pclk_seen = 0; val_seen = 0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (latch8) lat_seen++;
            if (pclk8) pclk_seen++;
            if (valid8 || btn8 !== exp_b) val_seen++;
        end
        checks++;
        if (lat_seen !== 0 || pclk_seen !== 0) begin
            errors++; $display("FAIL drop_idle: got latch %0d pclk %0d expected 0 0", lat_seen, pclk_seen);
        end
        checks++;
        if (val_seen !== 0) begin errors++; $display("FAIL drop_hold: got %0d expected 0", val_seen); end
    endtask

    task automatic test_reset_midpoll();
        int n, lh, rs, ph, vt;
        en8 = 1'b1;
        wait_latch8(10, n);
        checks++;
        if (latch8 !== 1'b1) begin errors++; $display("FAIL rst_latch_start: got %b expected 1", latch8); end
        n = 0;
        while (pclk8 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (pclk8 !== 1'b1 || btn8 !== prev8) begin
            errors++; $display("FAIL rst_pre: got pclk %b btn %h expected 1 %h", pclk8, btn8, prev8);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({latch8, pclk8, valid8, chg8, btn8} !== 21'h0) begin
            errors++; $display("FAIL rst_async: got %h expected 000000", {latch8, pclk8, valid8, chg8, btn8});
        end
        prev8 = 16'h0; prev16 = 16'h0;
        repeat (2) @(posedge clk);
        raw8[0] = 8'hF6; raw8[1] = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        wait_latch8(10, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL rst_first_latch: got %0d expected 4", n); end
        measure8(lh, rs, ph, vt);
        checks++;
        if (vt !== 64 || btn8 !== 16'h0009 || chg8 !== 2'b01) begin
            errors++; $display("FAIL rst_first_poll: got v%0d %h %b expected v64 0009 01", vt, btn8, chg8);
        end
        prev8 = 16'h0009;
        en8 = 1'b0;
    endtask

    task automatic test_snes();
        int n, rs, vt;
        logic [15:0] exp_b;
        raw16 = 16'h7FFF; en16 = 1'b1;
        wait_latch16(10, n);
        checks++;
        if (latch16 !== 1'b1) begin errors++; $display("FAIL snes_latch: got %b expected 1", latch16); end
        measure16(rs, vt);
        checks++;
        if (vt !== 128 || rs !== 15) begin
            errors++; $display("FAIL snes_timing: got v%0d r%0d expected v128 r15", vt, rs);
        end
        checks++;
        if (btn16 !== 16'h8000 || chg16 !== 1'b1) begin
            errors++; $display("FAIL snes_bit15: got %h/%b expected 8000/1", btn16, chg16);
        end
        prev16 = 16'h8000;
        @(posedge clk); #1;
        raw16 = 16'($urandom);
        exp_b = ~raw16;
        wait_latch16(60, n);
        checks++;
        if (n !== 31) begin errors++; $display("FAIL snes_gap: got %0d expected 31", n); end
        measure16(rs, vt);
        checks++;
        if (vt !== 128 || btn16 !== exp_b || chg16 !== 1'((exp_b != prev16))) begin
            errors++; $display("FAIL snes_random: got v%0d %h/%b expected v128 %h/%b", vt, btn16, chg16, exp_b, (exp_b != prev16));
        end
        prev16 = exp_b;
        en16 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_poll();
        test_repeat_poll();
        test_random_polls();
        test_enable_drop();
        test_reset_midpoll();
        test_snes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_pad_reader
`default_nettype wire
